// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU encodings.
//   alu_op_e   - 2-bit ALUOp class coming from the main decoder.
//   alu_ctrl_e - 4-bit ALUControl operation codes understood by the ALU.
// Used by the issue stage decoder (alu_control) and by the ALU itself.
package alu_pkg;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0100,
        ALU_SUB = 4'b0110,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_SRA = 4'b1010,
        ALU_DEF = 4'b1111
    } alu_ctrl_e;

    localparam int unsigned XLEN = 64;

endpackage

// File: rtl/alu_control.sv
// alu_control: combinational ALUControl decode.
// Ports:
//   alu_op      in  2  instruction class (mem / branch / R-type / I-type)
//   funct3      in  3  instruction funct3
//   funct7b5    in  1  instruction bit 30
//   alu_control out 4  ALU operation code (alu_pkg::alu_ctrl_e)
module alu_control
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_DEF;
        case (alu_op_e'(alu_op))
            ALUOP_MEM:    alu_control = ALU_ADD;
            ALUOP_BRANCH: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    // bit 30 only means SUB for register-register ops; for
                    // ADDI it is just an immediate bit.
                    3'b000: alu_control = (alu_op_e'(alu_op) == ALUOP_RTYPE && funct7b5)
                                          ? ALU_SUB : ALU_ADD;
                    3'b111: alu_control = ALU_AND;
                    3'b110: alu_control = ALU_OR;
                    3'b100: alu_control = ALU_XOR;
                    3'b001: alu_control = ALU_SLL;
                    // shifts: bit 30 picks arithmetic for both SRA and SRAI
                    3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    default: alu_control = ALU_DEF; // SLT/SLTU not supported
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: single-entry registered issue stage in front of the ALU.
// Captures operand A (rs1 data), operand B (rs2 data or immediate) and the
// decoded ALUControl; one cycle from in_valid to out_valid.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   ALUOp, Funct3, Funct7b5    decode inputs
//   ALUSrc                     1: B takes Imm, 0: B takes RegB
//   RegA, RegB, Imm            operand sources
//   flush                      kill stage contents (highest priority)
//   out_valid / out_ready      downstream handshake
//   A, B, ALUControl           registered ALU operands and op code
// Optional feature macro ALU_ISSUE_FWD_EN adds forwarding ports
//   Rs1, Rs2, ExMemRd, ExMemRegWrite, ExMemResult, MemWbRd, MemWbRegWrite,
//   MemWbData and selects forwarded operands at capture time.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready; ready upstream is
// !out_valid || out_ready, so a full stage can drain and refill in one edge.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      Funct3,
    input  logic            Funct7b5,
    input  logic            ALUSrc,
    input  logic [XLEN-1:0] RegA,
    input  logic [XLEN-1:0] RegB,
    input  logic [XLEN-1:0] Imm,
`ifdef ALU_ISSUE_FWD_EN
    input  logic [4:0]      Rs1,
    input  logic [4:0]      Rs2,
    input  logic [4:0]      ExMemRd,
    input  logic            ExMemRegWrite,
    input  logic [XLEN-1:0] ExMemResult,
    input  logic [4:0]      MemWbRd,
    input  logic            MemWbRegWrite,
    input  logic [XLEN-1:0] MemWbData,
`endif
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [3:0]      ALUControl
);

    logic [3:0]      ctrl_next;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb_reg;
    logic            take;

    alu_control u_alu_control (
        .alu_op      (ALUOp),
        .funct3      (Funct3),
        .funct7b5    (Funct7b5),
        .alu_control (ctrl_next)
    );

`ifdef ALU_ISSUE_FWD_EN
    // EX/MEM is younger than MEM/WB, so it wins when both match.
    logic exmem_a, exmem_b, memwb_a, memwb_b;
    assign exmem_a = ExMemRegWrite && (ExMemRd != 5'd0) && (ExMemRd == Rs1);
    assign exmem_b = ExMemRegWrite && (ExMemRd != 5'd0) && (ExMemRd == Rs2);
    assign memwb_a = MemWbRegWrite && (MemWbRd != 5'd0) && (MemWbRd == Rs1);
    assign memwb_b = MemWbRegWrite && (MemWbRd != 5'd0) && (MemWbRd == Rs2);
    assign opa     = exmem_a ? ExMemResult : (memwb_a ? MemWbData : RegA);
    assign opb_reg = exmem_b ? ExMemResult : (memwb_b ? MemWbData : RegB);
`else
    assign opa     = RegA;
    assign opb_reg = RegB;
`endif

    assign in_ready = !out_valid || out_ready;
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            A          <= '0;
            B          <= '0;
            ALUControl <= 4'b0000;
        end else if (flush) begin
            // held operands stay as they were; only validity is killed
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid  <= 1'b1;
            A          <= opa;
            B          <= ALUSrc ? Imm : opb_reg;
            ALUControl <= ctrl_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: self-checking bench for alu_issue_stage.
// Build with +define+ALU_ISSUE_FWD_EN to exercise the forwarding ports.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUOp;
    logic [2:0]  Funct3;
    logic        Funct7b5;
    logic        ALUSrc;
    logic [63:0] RegA, RegB, Imm;
`ifdef ALU_ISSUE_FWD_EN
    logic [4:0]  Rs1, Rs2, ExMemRd, MemWbRd;
    logic        ExMemRegWrite, MemWbRegWrite;
    logic [63:0] ExMemResult, MemWbData;
`endif
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] A, B;
    logic [3:0]  ALUControl;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: pending entry {A,B,ctrl} and last captured contents
    logic [131:0] exp_q[$];
    logic [131:0] m_last;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct3(Funct3), .Funct7b5(Funct7b5), .ALUSrc(ALUSrc),
        .RegA(RegA), .RegB(RegB), .Imm(Imm),
`ifdef ALU_ISSUE_FWD_EN
        .Rs1(Rs1), .Rs2(Rs2), .ExMemRd(ExMemRd), .ExMemRegWrite(ExMemRegWrite),
        .ExMemResult(ExMemResult), .MemWbRd(MemWbRd), .MemWbRegWrite(MemWbRegWrite),
        .MemWbData(MemWbData),
`endif
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .ALUControl(ALUControl)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference functions ----------------
    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f7);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (f3 == 3'b000) return (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
        if (f3 == 3'b111) return 4'b0000;
        if (f3 == 3'b110) return 4'b0001;
        if (f3 == 3'b100) return 4'b0100;
        if (f3 == 3'b001) return 4'b1000;
        if (f3 == 3'b101) return f7 ? 4'b1010 : 4'b1001;
        return 4'b1111;
    endfunction

    function automatic logic [63:0] ref_a();
`ifdef ALU_ISSUE_FWD_EN
        if (ExMemRegWrite && ExMemRd != 0 && ExMemRd == Rs1) return ExMemResult;
        if (MemWbRegWrite && MemWbRd != 0 && MemWbRd == Rs1) return MemWbData;
`endif
        return RegA;
    endfunction

    function automatic logic [63:0] ref_b();
        logic [63:0] r;
        r = RegB;
`ifdef ALU_ISSUE_FWD_EN
        if (ExMemRegWrite && ExMemRd != 0 && ExMemRd == Rs2) r = ExMemResult;
        else if (MemWbRegWrite && MemWbRd != 0 && MemWbRd == Rs2) r = MemWbData;
`endif
        return ALUSrc ? Imm : r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        in_valid = 0; out_ready = 0; flush = 0;
        ALUOp = 0; Funct3 = 0; Funct7b5 = 0; ALUSrc = 0;
        RegA = 0; RegB = 0; Imm = 0;
`ifdef ALU_ISSUE_FWD_EN
        Rs1 = 0; Rs2 = 0; ExMemRd = 0; MemWbRd = 0;
        ExMemRegWrite = 0; MemWbRegWrite = 0; ExMemResult = 0; MemWbData = 0;
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last = '0;
    endtask

    // Called just after a falling edge with inputs set: checks in_ready,
    // advances one rising edge, updates the model, checks outputs at the
    // following falling edge.
    task automatic tick();
        logic [131:0] e;
        #1;
        n_checks++;
        if (in_ready !== (exp_q.size() == 0 || out_ready)) begin
            n_errors++;
            $display("FAIL in_ready: got %b expected %b", in_ready, (exp_q.size() == 0 || out_ready));
        end
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
        end else if (in_valid && (exp_q.size() == 0 || out_ready)) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            e = {ref_a(), ref_b(), ref_ctrl(ALUOp, Funct3, Funct7b5)};
            exp_q.push_back(e);
            m_last = e;
        end else if (exp_q.size() != 0 && out_ready) begin
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== (exp_q.size() != 0)) begin
            n_errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, (exp_q.size() != 0));
        end
        n_checks++;
        if ({A, B, ALUControl} !== m_last) begin
            n_errors++;
            $display("FAIL contents: got A=%h B=%h ctrl=%b expected A=%h B=%h ctrl=%b",
                     A, B, ALUControl, m_last[131:68], m_last[67:4], m_last[3:0]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #3;
        n_checks++;
        if (out_valid !== 0 || A !== 0 || B !== 0 || ALUControl !== 0) begin
            n_errors++;
            $display("FAIL reset_state: got v=%b A=%h B=%h ctrl=%b expected all zero",
                     out_valid, A, B, ALUControl);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_after_reset: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_rtype_sub();
        @(negedge clk);
        idle_inputs();
        in_valid = 1; ALUOp = 2'b10; Funct3 = 3'b000; Funct7b5 = 1;
        RegA = 64'd100; RegB = 64'd50; Imm = 64'd999;
        tick();
        n_checks++;
        if (out_valid !== 1 || ALUControl !== 4'b0110 || A !== 64'd100 || B !== 64'd50) begin
            n_errors++;
            $display("FAIL rtype_sub: got v=%b ctrl=%b A=%0d B=%0d expected 1 0110 100 50",
                     out_valid, ALUControl, A, B);
        end
    endtask

    task automatic test_srai();
        idle_inputs();
        in_valid = 1; out_ready = 1; ALUOp = 2'b11; Funct3 = 3'b101; Funct7b5 = 1;
        ALUSrc = 1; Imm = 64'd1; RegA = 64'h55; RegB = 64'h77;
        tick();
        n_checks++;
        if (ALUControl !== 4'b1010 || B !== 64'd1) begin
            n_errors++;
            $display("FAIL srai: got ctrl=%b B=%h expected 1010 1", ALUControl, B);
        end
    endtask

    task automatic test_stall_and_refill();
        // stage full from previous test; hold it with out_ready low
        idle_inputs();
        in_valid = 1; out_ready = 0; ALUOp = 2'b00; RegA = 64'hAAAA; RegB = 64'hBBBB;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (in_ready !== 0 || ALUControl !== 4'b1010 || B !== 64'd1 || A !== 64'h55) begin
                n_errors++;
                $display("FAIL stall_hold: got rdy=%b ctrl=%b A=%h B=%h expected 0 1010 55 1",
                         in_ready, ALUControl, A, B);
            end
        end
        out_ready = 1;
        tick();
        n_checks++;
        if (out_valid !== 1 || A !== 64'hAAAA || B !== 64'hBBBB || ALUControl !== 4'b0010) begin
            n_errors++;
            $display("FAIL refill: got v=%b A=%h B=%h ctrl=%b expected 1 aaaa bbbb 0010",
                     out_valid, A, B, ALUControl);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid = 1; out_ready = 1; flush = 1; ALUOp = 2'b01; RegA = 64'h1234;
        tick();
        n_checks++;
        if (out_valid !== 0 || A !== 64'hAAAA) begin
            n_errors++;
            $display("FAIL flush: got v=%b A=%h expected 0 aaaa", out_valid, A);
        end
        flush = 0;
    endtask

    task automatic test_reset_mid_hold();
        idle_inputs();
        in_valid = 1; ALUOp = 2'b10; Funct3 = 3'b111; RegA = 64'hDEAD; RegB = 64'hBEEF;
        tick();
        in_valid = 0; out_ready = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        n_checks++;
        if (out_valid !== 0 || A !== 0 || B !== 0 || ALUControl !== 0) begin
            n_errors++;
            $display("FAIL async_reset: got v=%b A=%h B=%h ctrl=%b expected all zero",
                     out_valid, A, B, ALUControl);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_after_mid_reset: got %b expected 1", in_ready);
        end
    endtask

`ifdef ALU_ISSUE_FWD_EN
    task automatic test_forwarding();
        idle_inputs();
        in_valid = 1; out_ready = 1; RegA = 64'd123;
        Rs1 = 5; ExMemRd = 5; MemWbRd = 5; ExMemRegWrite = 1; MemWbRegWrite = 1;
        ExMemResult = 64'd7; MemWbData = 64'd9;
        tick();
        n_checks++;
        if (A !== 64'd7) begin
            n_errors++;
            $display("FAIL fwd_exmem: got A=%0d expected 7", A);
        end
        Rs1 = 0;
        tick();
        n_checks++;
        if (A !== 64'd123) begin
            n_errors++;
            $display("FAIL fwd_rs1_zero: got A=%0d expected 123", A);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 11) == 0);
            ALUOp     = 2'($urandom_range(0, 3));
            Funct3    = 3'($urandom_range(0, 7));
            Funct7b5  = 1'($urandom_range(0, 1));
            ALUSrc    = 1'($urandom_range(0, 1));
            RegA      = {$urandom, $urandom};
            RegB      = {$urandom, $urandom};
            Imm       = {$urandom, $urandom};
`ifdef ALU_ISSUE_FWD_EN
            Rs1 = 5'($urandom_range(0, 3)); Rs2 = 5'($urandom_range(0, 3));
            ExMemRd = 5'($urandom_range(0, 3)); MemWbRd = 5'($urandom_range(0, 3));
            ExMemRegWrite = 1'($urandom_range(0, 1)); MemWbRegWrite = 1'($urandom_range(0, 1));
            ExMemResult = {$urandom, $urandom}; MemWbData = {$urandom, $urandom};
`endif
            tick();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_rtype_sub();
        test_srai();
        test_stall_and_refill();
        test_flush();
        test_reset_mid_hold();
`ifdef ALU_ISSUE_FWD_EN
        test_forwarding();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-002 The block SHALL have these ports:
- in_valid  input  1  decoded instruction present
- in_ready  output 1  stage can accept
- ALUOp  input  2  00 mem, 01 branch, 10 R-type, 11 I-type
- Funct3  input  3  instruction funct3
- Funct7b5  input  1  instruction bit 30
- ALUSrc  input  1  1 selects Imm as B
- RegA  input  64  rs1 read data
- RegB  input  64  rs2 read data
- Imm  input  64  sign-extended immediate
- flush  input  1  kill stage contents
- out_valid  output 1  A/B/ALUControl valid
- out_ready  input  1  ALU/EX consumer accepts
- A  output 64  ALU operand A
- B  output 64  ALU operand B
- ALUControl  output 4  ALU operation code

Function
REQ-003 The stage SHALL be a single-entry registered pipeline stage; latency in_valid to out_valid is exactly 1 cycle.
REQ-004 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-005 A transfer in SHALL occur on a rising edge with in_valid && in_ready; A, B and ALUControl are captured and out_valid is set.
REQ-006 When out_valid && out_ready and no new transfer in, out_valid SHALL clear; held A/B/ALUControl are unchanged.
REQ-007 While out_valid && !out_ready, A, B, ALUControl SHALL remain stable.
REQ-008 Simultaneous drain and fill (out_ready && in_valid while full) SHALL replace contents in the same edge with no bubble.
REQ-009 flush SHALL clear out_valid on the next edge and suppress any same-cycle capture; flush has priority over all transfers.
REQ-010 B SHALL be captured as Imm when ALUSrc=1, else RegB; A SHALL be captured as RegA.
REQ-011 ALUControl decode SHALL be:
- ALUOp=00 -> 0010 (ADD).
- ALUOp=01 -> 0110 (SUB).
- ALUOp=10/11, Funct3: 000 -> 0010, except ALUOp=10 && Funct7b5=1 -> 0110.
- Funct3 111 -> 0000; 110 -> 0001; 100 -> 0100; 001 -> 1000.
- Funct3 101 -> 1001 if Funct7b5=0, else 1010.
- Funct3 010/011 -> 1111 (unsupported, ALU default).

Reset
REQ-012 On rst_n low, out_valid SHALL be 0 and A, B SHALL be 64'h0 and ALUControl 4'b0000, immediately and asynchronously; reset mid-transfer discards the held instruction.
REQ-013 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-014 Macro ALU_ISSUE_FWD_EN SHALL add these ports:
- Rs1  input  5
- Rs2  input  5
- ExMemRd  input  5
- ExMemRegWrite  input  1
- ExMemResult  input  64
- MemWbRd  input  5
- MemWbRegWrite  input  1
- MemWbData  input  64
REQ-015 With ALU_ISSUE_FWD_EN, operand forwarding SHALL be applied at capture:
- Rs1 matches ExMemRd (ExMemRegWrite, Rd!=0) -> use ExMemResult.
- Otherwise, a MemWb match -> use MemWbData.
- Otherwise, use RegA.
- Rs2/RegB is forwarded the same way before the ALUSrc mux.
REQ-016 Without ALU_ISSUE_FWD_EN, the extra ports SHALL be absent and operands SHALL come directly from RegA/RegB.

Structure
REQ-017 ALUOp encodings and the 4-bit ALUControl codes (AND, OR, ADD, XOR, SUB, SLL, SRL, SRA, DEF=1111) SHALL live in shared package alu_pkg, also used by the ALU.
REQ-018 Decode SHALL be a separate combinational sub-module alu_control; forwarding muxes stay inline.

Verification
REQ-019 Bench SHALL cover:
- ALUOp=10, Funct3=000, Funct7b5=1, RegA=100, RegB=50 -> one cycle later out_valid=1, ALUControl=0110, A=100, B=50.
- ALUOp=11, Funct3=101, Funct7b5=1, ALUSrc=1, Imm=1 -> ALUControl=1010, B=1.
- Full with out_ready=0 for 3 cycles -> in_ready=0, outputs stable; then out_ready=1 with in_valid=1 -> new contents next edge, out_valid stays 1.
- flush=1 with in_valid=1 -> out_valid=0 next edge.
- rst_n pulsed low mid-hold -> out_valid=0, A=B=0 immediately.
- FWD_EN: Rs1=5, ExMemRd=5, MemWbRd=5, both RegWrite=1, ExMemResult=7, MemWbData=9 -> A=7; with Rs1=0 -> A=RegA.
